stack_sequencer: RTL

- Multi-cycle micro-sequencer that executes PUSH, POP, CALL and RET.
- It is the driving side of the 16x16 register file interface: it issues the register-file selects, write enables and SP inc/dec strobes, and reads back the src/dst read ports.
- It also performs the stack memory access over a req/ack bus.
- Sits between the instruction decoder (start/op) and the register file plus data memory.

---
 rtl/stack_sequencer_if.sv | 44 ++++
 rtl/stack_sequencer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/stack_sequencer_if.sv
// Bundles the decoder handshake, register-file port and stack-memory bus
// seen by stack_sequencer.
//   master : the sequencer side (drives selects, strobes, memory request)
//   slave  : the environment side (decoder, register file, data memory)
// Signal groups:
//   start/op/reg_sel            decoder request
//   rf_src_sel/rf_dst_sel/rf_in/rf_in_en/rf_sp_inc/rf_sp_dec  rf control
//   rf_src/rf_dst               rf read ports
//   mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ack       memory bus
//   busy/done/fault             status
interface stack_sequencer_if;
   logic        start;
   logic [1:0]  op;
   logic [3:0]  reg_sel;
   logic [3:0]  rf_src_sel;
   logic [3:0]  rf_dst_sel;
   logic [15:0] rf_in;
   logic        rf_in_en;
   logic        rf_sp_inc;
   logic        rf_sp_dec;
   logic [15:0] rf_src;
   logic [15:0] rf_dst;
   logic        mem_req;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        mem_ack;
   logic        busy;
   logic        done;
   logic        fault;

   modport master (
      input  start, op, reg_sel, rf_src, rf_dst, mem_rdata, mem_ack,
      output rf_src_sel, rf_dst_sel, rf_in, rf_in_en, rf_sp_inc, rf_sp_dec,
             mem_req, mem_we, mem_addr, mem_wdata, busy, done, fault
   );

   modport slave (
      output start, op, reg_sel, rf_src, rf_dst, mem_rdata, mem_ack,
      input  rf_src_sel, rf_dst_sel, rf_in, rf_in_en, rf_sp_inc, rf_sp_dec,
             mem_req, mem_we, mem_addr, mem_wdata, busy, done, fault
   );
endinterface

// File: rtl/stack_sequencer.sv
// Multi-cycle micro-sequencer for PUSH / POP / CALL / RET.
// Drives the 16x16 register file (selects, write strobe, SP inc/dec) and
// performs the single stack-memory access over a req/ack bus.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - stack_sequencer_if.master (decoder, register file, memory, status)
// Register conventions: r1 = PC, r2 = SP, r3 = BA (call target).
module stack_sequencer #(
   parameter logic [15:0] STACK_BASE  = 16'h0100,
   parameter logic [15:0] STACK_LIMIT = 16'h00C0
) (
   input logic clk,
   input logic rst,
   stack_sequencer_if.master bus
);

   typedef enum logic [1:0] {
      OP_PUSH = 2'b00,
      OP_POP  = 2'b01,
      OP_CALL = 2'b10,
      OP_RET  = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_MEM, S_WB, S_DONE, S_FAULT
   } state_e;

   localparam logic [3:0] R_PC = 4'd1;
   localparam logic [3:0] R_SP = 4'd2;
   localparam logic [3:0] R_BA = 4'd3;

   state_e      state;
   op_e         op_q;
   logic [3:0]  reg_q;
   logic [15:0] addr_q;
   logic [15:0] data_q;
   logic [15:0] rdata_q;
   logic        mem_req_q;
   logic        mem_we_q;
   logic        busy_q;
   logic        done_q;
   logic        fault_q;

   // PUSH and CALL write the stack (SP pre-decrement); POP and RET read it.
   logic is_wr;
   assign is_wr = (op_q == OP_PUSH) || (op_q == OP_CALL);

   // Control FSM. Memory outputs and status are all registered here.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         op_q      <= OP_PUSH;
         reg_q     <= 4'd0;
         addr_q    <= 16'd0;
         data_q    <= 16'd0;
         rdata_q   <= 16'd0;
         mem_req_q <= 1'b0;
         mem_we_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         fault_q   <= 1'b0;
      end else begin
         done_q  <= 1'b0;
         fault_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  op_q   <= op_e'(bus.op);
                  reg_q  <= bus.reg_sel;
                  busy_q <= 1'b1;
                  state  <= S_FETCH;
               end
            end
            S_FETCH: begin
               if (is_wr) begin
                  if (bus.rf_dst == STACK_LIMIT) begin
                     fault_q <= 1'b1;
                     state   <= S_FAULT;
                  end else begin
                     // rf_src is sampled before the SP decrement lands, so
                     // PUSH r2 stores the old SP.
                     data_q    <= bus.rf_src;
                     addr_q    <= bus.rf_dst - 16'd1;
                     mem_we_q  <= 1'b1;
                     mem_req_q <= 1'b1;
                     state     <= S_MEM;
                  end
               end else begin
                  if (bus.rf_dst == STACK_BASE) begin
                     fault_q <= 1'b1;
                     state   <= S_FAULT;
                  end else begin
                     addr_q    <= bus.rf_dst;
                     mem_we_q  <= 1'b0;
                     mem_req_q <= 1'b1;
                     state     <= S_MEM;
                  end
               end
            end
            S_MEM: begin
               // No timeout: the bus owns completion.
               if (bus.mem_ack) begin
                  mem_req_q <= 1'b0;
                  mem_we_q  <= 1'b0;
                  if (!mem_we_q) rdata_q <= bus.mem_rdata;
                  if (op_q == OP_PUSH) begin
                     done_q <= 1'b1;
                     state  <= S_DONE;
                  end else begin
                     state  <= S_WB;
                  end
               end
            end
            S_WB: begin
               done_q <= 1'b1;
               state  <= S_DONE;
            end
            S_DONE, S_FAULT: begin
               busy_q <= 1'b0;
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Register-file control decodes from state and latched op. The SP
   // strobes also depend on the live SP read so that a faulting op leaves
   // SP untouched.
   always_comb begin
      bus.rf_src_sel = 4'd0;
      bus.rf_dst_sel = 4'd0;
      bus.rf_in      = 16'd0;
      bus.rf_in_en   = 1'b0;
      bus.rf_sp_inc  = 1'b0;
      bus.rf_sp_dec  = 1'b0;
      case (state)
         S_FETCH: begin
            bus.rf_dst_sel = R_SP;
            if (is_wr) begin
               bus.rf_src_sel = (op_q == OP_PUSH) ? reg_q : R_PC;
               bus.rf_sp_dec  = (bus.rf_dst != STACK_LIMIT);
            end else begin
               bus.rf_sp_inc  = (bus.rf_dst != STACK_BASE);
            end
         end
         S_WB: begin
            case (op_q)
               OP_POP: begin
                  bus.rf_dst_sel = reg_q;
                  bus.rf_in      = rdata_q;
                  bus.rf_in_en   = 1'b1;
               end
               OP_RET: begin
                  bus.rf_dst_sel = R_PC;
                  bus.rf_in      = rdata_q;
                  bus.rf_in_en   = 1'b1;
               end
               OP_CALL: begin
                  bus.rf_src_sel = R_BA;
                  bus.rf_dst_sel = R_PC;
                  bus.rf_in      = bus.rf_src;
                  bus.rf_in_en   = 1'b1;
               end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = data_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.fault     = fault_q;

endmodule
